// File: rtl/trng_health_buffer.sv
// trng_health_buffer: monobit/repetition health test on raw TRNG words, feeding a FWFT FIFO with an alarm lockout
module trng_health_buffer #(
    parameter int DEPTH      = 8,
    parameter int ONES_MIN   = 16,
    parameter int ONES_MAX   = 48,
    parameter int FAIL_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              in_data,
    input  logic                     in_valid,
    output logic [63:0]              m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    input  logic                     clear_alarm,
    output logic                     alarm,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [3:0]    FAIL_LIM = FAIL_LIMIT[3:0];

    typedef enum logic {RUN, ALARM} state_t;

    state_t        state_q, state_d;
    logic [63:0]   prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic [63:0]   s1_data_q, s1_data_d;
    logic          s1_vld_q, s1_vld_d;
    logic [3:0]    fail_q, fail_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [6:0]    ones;
    logic          word_ok, pop, wr_try, full, wr_en, drop;

    // Health tests on the incoming word: popcount window and repeat of the previous word
    always_comb begin
        ones = '0;
        for (int i = 0; i < 64; i++) ones = ones + {6'd0, in_data[i]};
        word_ok = (ones >= 7'(ONES_MIN)) && (ones <= 7'(ONES_MAX)) && !(prev_vld_q && in_data == prev_q);
    end

    // FIFO handshake: a full FIFO still accepts a write when the head pops in the same cycle
    always_comb begin
        m_tvalid = (state_q == RUN) && (lvl_q != '0);
        pop      = m_tvalid && m_tready;
        full     = lvl_q == LVL_FULL;
        wr_try   = (state_q == RUN) && s1_vld_q;
        wr_en    = wr_try && (!full || pop);
        drop     = wr_try && full && !pop;
    end

    // Next-state: test stage, fail counter, alarm entry/exit, FIFO pointers and drop statistics
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        s1_data_d  = s1_data_q;
        s1_vld_d   = 1'b0;
        fail_d     = fail_q;
        mem_d      = mem_q;
        if (wr_en) mem_d[wr_q] = s1_data_q;
        wr_d   = wr_en ? wr_q + PTR_ONE : wr_q;
        rd_d   = pop ? rd_q + PTR_ONE : rd_q;
        lvl_d  = lvl_q + (wr_en ? LVL_ONE : '0) - (pop ? LVL_ONE : '0);
        ovf_d  = ovf_q | drop;
        drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        if (state_q == RUN) begin
            if (in_valid) begin
                prev_d     = in_data;
                prev_vld_d = 1'b1;
                s1_data_d  = in_data;
                s1_vld_d   = word_ok;
                fail_d     = word_ok ? 4'd0 : fail_q + 4'd1;
                if (!word_ok && fail_q + 4'd1 >= FAIL_LIM) state_d = ALARM;
            end
        end else if (clear_alarm) begin
            state_d    = RUN;
            fail_d     = 4'd0;
            prev_vld_d = 1'b0;
        end
        if (state_d == ALARM) begin
            s1_vld_d = 1'b0;
            wr_d     = '0;
            rd_d     = '0;
            lvl_d    = '0;
        end
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            s1_data_q  <= '0;
            s1_vld_q   <= 1'b0;
            fail_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            lvl_q      <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            s1_data_q  <= s1_data_d;
            s1_vld_q   <= s1_vld_d;
            fail_q     <= fail_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            lvl_q      <= lvl_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // Storage array; contents are never visible while empty, so it needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign m_tdata    = m_tvalid ? mem_q[rd_q] : '0;
    assign alarm      = state_q == ALARM;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign fifo_level = lvl_q;
endmodule
